// File: rtl/branch_resolver.sv
// Update side of the 16-entry tagged 1-bit branch predictor: queues fetch-time lookups and resolves them at execute.
// Optional BRANCH_RESOLVER_STATS_EN adds resolved-branch and redirect counters.
module branch_resolver #(
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  input  logic [31:0] f_pc4,
  input  logic        f_hit,
  input  logic        f_pred,
  input  logic [31:0] f_bdest,
  output logic        f_ready,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        wrt,
  output logic        wrp,
  output logic        Pin,
  output logic [31:0] BdestIN,
  output logic [31:0] PC4d,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        underflow
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int CNTW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef struct packed {
    logic [31:0] pc4;
    logic        hit;
    logic        pred;
    logic [31:0] bdest;
  } rec_t;

  typedef enum logic {ACTIVE, RECOVER} state_t;

  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic [CNTW-1:0] drain_q, drain_d;

  logic        wrt_q, wrt_d, wrp_q, wrp_d, pin_q, pin_d;
  logic [31:0] bdest_q, bdest_d, pc4d_q, pc4d_d, rpc_q, rpc_d;
  logic        redirect_q, redirect_d, underflow_q, underflow_d;

  rec_t head;
  logic empty, full, ex_accept, pred_taken, mispredict, push;

  assign head       = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign ex_accept  = (state_q == ACTIVE) && ex_valid && !empty;
  assign pred_taken = head.hit && head.pred;
  assign f_ready    = !full || ex_accept;
  // A push arriving alongside a mispredict is on the wrong path.
  assign push       = f_valid && f_ready && !mispredict;

  always_comb begin
    wrt_d      = 1'b0;
    wrp_d      = 1'b0;
    pin_d      = 1'b0;
    bdest_d    = '0;
    pc4d_d     = '0;
    redirect_d = 1'b0;
    rpc_d      = '0;
    mispredict = 1'b0;
    if (ex_accept) begin
      if (ex_is_branch) begin
        if (ex_taken) begin
          wrt_d      = 1'b1;
          wrp_d      = 1'b1;
          pin_d      = 1'b1;
          bdest_d    = ex_target;
          mispredict = !pred_taken || (head.bdest != ex_target);
        end else begin
          wrp_d      = head.hit;
          mispredict = pred_taken;
        end
      end else if (pred_taken) begin
        // Tag alias on a non-branch: clear the prediction and fall through.
        wrp_d      = 1'b1;
        mispredict = 1'b1;
      end
      if (wrt_d || wrp_d) pc4d_d = head.pc4;
      redirect_d = mispredict;
      if (mispredict) rpc_d = (ex_is_branch && ex_taken) ? ex_target : head.pc4;
    end
    underflow_d = underflow_q || ((state_q == ACTIVE) && ex_valid && empty);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)      wr_ptr_d = wr_ptr_q + AW'(1);
      if (ex_accept) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(ex_accept);
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ACTIVE: begin
        if (mispredict && (DRAIN_CYCLES > 0)) begin
          state_d = RECOVER;
          drain_d = CNTW'(DRAIN_CYCLES);
        end
      end
      RECOVER: begin
        drain_d = drain_q - CNTW'(1);
        if (drain_q <= CNTW'(1)) state_d = ACTIVE;
      end
      default: begin
        state_d = ACTIVE;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc4: f_pc4, hit: f_hit, pred: f_pred, bdest: f_bdest};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ACTIVE;
      drain_q     <= '0;
      wrt_q       <= 1'b0;
      wrp_q       <= 1'b0;
      pin_q       <= 1'b0;
      bdest_q     <= '0;
      pc4d_q      <= '0;
      redirect_q  <= 1'b0;
      rpc_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      drain_q     <= drain_d;
      wrt_q       <= wrt_d;
      wrp_q       <= wrp_d;
      pin_q       <= pin_d;
      bdest_q     <= bdest_d;
      pc4d_q      <= pc4d_d;
      redirect_q  <= redirect_d;
      rpc_q       <= rpc_d;
      underflow_q <= underflow_d;
    end
  end

  assign wrt         = wrt_q;
  assign wrp         = wrp_q;
  assign Pin         = pin_q;
  assign BdestIN     = bdest_q;
  assign PC4d        = pc4d_q;
  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;
  assign underflow   = underflow_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (ex_accept && ex_is_branch) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: table-driven resolutions plus full-FIFO, drain and async-reset sequences.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid, f_hit, f_pred, f_ready;
  logic [31:0] f_pc4, f_bdest;
  logic        ex_valid, ex_is_branch, ex_taken;
  logic [31:0] ex_target;
  logic        wrt, wrp, Pin, redirect, underflow;
  logic [31:0] BdestIN, PC4d, redirect_pc;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches, stat_mispred;
`endif

  branch_resolver #(.DEPTH(8), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_pc4(f_pc4), .f_hit(f_hit), .f_pred(f_pred), .f_bdest(f_bdest),
    .f_ready(f_ready),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .wrt(wrt), .wrp(wrp), .Pin(Pin), .BdestIN(BdestIN), .PC4d(PC4d),
    .redirect(redirect), .redirect_pc(redirect_pc), .underflow(underflow)
`ifdef BRANCH_RESOLVER_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    int          due;
    string       tag;
    logic        wrt, wrp, pin;
    logic [31:0] bdest, pc4d;
    logic        redir;
    logic [31:0] rpc;
    logic        uf;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [31:0] pc4;
    logic        hit, pred;
    logic [31:0] bdest;
    logic        is_br, taken;
    logic [31:0] target;
    logic        wrt, wrp, pin;
    logic [31:0] e_bdest, e_pc4d;
    logic        redir;
    logic [31:0] e_rpc;
  } vec_t;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_wrt, input logic e_wrp, input logic e_pin,
                            input logic [31:0] e_bdest, input logic [31:0] e_pc4d, input logic e_redir,
                            input logic [31:0] e_rpc, input logic e_uf);
    exp_t e;
    e.due = cyc + 1; e.tag = tag;
    e.wrt = e_wrt; e.wrp = e_wrp; e.pin = e_pin; e.bdest = e_bdest; e.pc4d = e_pc4d;
    e.redir = e_redir; e.rpc = e_rpc; e.uf = e_uf;
    exp_q.push_back(e);
  endtask

  // Scoreboard: pop the expectation due this cycle and compare; data fields only where qualified.
  always @(negedge clk) begin : mon
    exp_t e;
    logic ok;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e  = exp_q.pop_front();
      ok = (wrt === e.wrt) && (wrp === e.wrp) && (redirect === e.redir) && (underflow === e.uf);
      if (e.wrp && (Pin !== e.pin)) ok = 1'b0;
      if (e.wrt && (BdestIN !== e.bdest)) ok = 1'b0;
      if ((e.wrt || e.wrp) && (PC4d !== e.pc4d)) ok = 1'b0;
      if (e.redir && (redirect_pc !== e.rpc)) ok = 1'b0;
      nvec++;
      if (!ok) begin
        nmis++;
        $display("FAIL %s: got wrt=%b wrp=%b Pin=%b BdestIN=%h PC4d=%h redirect=%b redirect_pc=%h underflow=%b; want wrt=%b wrp=%b Pin=%b BdestIN=%h PC4d=%h redirect=%b redirect_pc=%h underflow=%b",
                 e.tag, wrt, wrp, Pin, BdestIN, PC4d, redirect, redirect_pc, underflow,
                 e.wrt, e.wrp, e.pin, e.bdest, e.pc4d, e.redir, e.rpc, e.uf);
      end
      $display("txn %s: wrt=%b wrp=%b Pin=%b PC4d=%h redirect=%b redirect_pc=%h", e.tag, wrt, wrp, Pin, PC4d, redirect, redirect_pc);
    end
  end

  task automatic idle_inputs();
    f_valid = 0; f_pc4 = 0; f_hit = 0; f_pred = 0; f_bdest = 0;
    ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_target = 0;
  endtask

  task automatic push_rec(input logic [31:0] pc4, input logic hit, input logic pred, input logic [31:0] bdest);
    f_valid = 1; f_pc4 = pc4; f_hit = hit; f_pred = pred; f_bdest = bdest;
    @(negedge clk);
    f_valid = 0;
  endtask

  task automatic drive_ex(input logic is_br, input logic taken, input logic [31:0] target);
    ex_valid = 1; ex_is_branch = is_br; ex_taken = taken; ex_target = target;
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    #3;
    check1("reset_flags", {27'd0, wrt, wrp, Pin, redirect, underflow}, 32'd0);
    check1("reset_data", BdestIN | PC4d | redirect_pc, 32'd0);
    check1("reset_f_ready", {31'd0, f_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // pc4 hit pred bdest | br tk target | wrt wrp Pin BdestIN PC4d redir rpc
    vecs[0] = '{32'h104, 0, 0, 32'h000, 1, 1, 32'h200, 1, 1, 1, 32'h200, 32'h104, 1, 32'h200};
    vecs[1] = '{32'h108, 1, 1, 32'h300, 1, 1, 32'h300, 1, 1, 1, 32'h300, 32'h108, 0, 32'h000};
    vecs[2] = '{32'h10C, 1, 1, 32'h300, 1, 0, 32'h000, 0, 1, 0, 32'h000, 32'h10C, 1, 32'h10C};
    vecs[3] = '{32'h110, 1, 1, 32'h300, 1, 1, 32'h400, 1, 1, 1, 32'h400, 32'h110, 1, 32'h400};
    vecs[4] = '{32'h114, 1, 0, 32'h500, 1, 0, 32'h000, 0, 1, 0, 32'h000, 32'h114, 0, 32'h000};
    vecs[5] = '{32'h118, 0, 1, 32'h000, 1, 0, 32'h000, 0, 0, 0, 32'h000, 32'h000, 0, 32'h000};
    vecs[6] = '{32'h11C, 1, 1, 32'h600, 0, 0, 32'h000, 0, 1, 0, 32'h000, 32'h11C, 1, 32'h11C};
    vecs[7] = '{32'h120, 0, 0, 32'h000, 0, 1, 32'h999, 0, 0, 0, 32'h000, 32'h000, 0, 32'h000};
    vecs[8] = '{32'h124, 1, 0, 32'h700, 1, 1, 32'h700, 1, 1, 1, 32'h700, 32'h124, 1, 32'h700};
    vecs[9] = '{32'h128, 0, 1, 32'h800, 1, 1, 32'h800, 1, 1, 1, 32'h800, 32'h128, 1, 32'h800};

    for (int i = 0; i < 10; i++) begin
      push_rec(vecs[i].pc4, vecs[i].hit, vecs[i].pred, vecs[i].bdest);
      drive_ex(vecs[i].is_br, vecs[i].taken, vecs[i].target);
      expect_out($sformatf("vec%0d", i), vecs[i].wrt, vecs[i].wrp, vecs[i].pin, vecs[i].e_bdest,
                 vecs[i].e_pc4d, vecs[i].redir, vecs[i].e_rpc, 1'b0);
      @(negedge clk);
      ex_valid = 0;
      repeat (3) @(negedge clk);
    end

    // Fill to DEPTH, drop a 9th push, then push+pop while full.
    for (int i = 0; i < 8; i++) push_rec(32'h1000 + 32'(4 * i), 1, 0, 32'h0);
    #1;
    check1("full_f_ready", {31'd0, f_ready}, 32'd0);
    push_rec(32'h2000, 1, 0, 32'h0);
    f_valid = 1; f_pc4 = 32'h3000; f_hit = 1; f_pred = 0; f_bdest = 0;
    drive_ex(1, 0, 32'h0);
    #1;
    check1("full_pushpop_ready", {31'd0, f_ready}, 32'd1);
    expect_out("full_pop0", 0, 1, 0, 32'h0, 32'h1000, 0, 32'h0, 0);
    @(negedge clk);
    f_valid = 0;
    for (int i = 1; i < 9; i++) begin
      expect_out($sformatf("full_pop%0d", i), 0, 1, 0, 32'h0,
                 (i == 8) ? 32'h3000 : 32'h1000 + 32'(4 * i), 0, 32'h0, 0);
      @(negedge clk);
    end
    ex_valid = 0;
    #1;
    check1("drained_f_ready", {31'd0, f_ready}, 32'd1);
    @(negedge clk);

    // Mispredict at T with a wrong-path push; ex_valid ignored during drain.
    push_rec(32'h500, 1, 1, 32'h600);
    f_valid = 1; f_pc4 = 32'h504; f_hit = 1; f_pred = 0; f_bdest = 0;
    drive_ex(1, 0, 32'h0);
    expect_out("drain_T", 0, 1, 0, 32'h0, 32'h500, 1, 32'h500, 0);
    @(negedge clk);
    f_pc4 = 32'h508;
    expect_out("drain_ign1", 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    f_valid = 0;
    expect_out("drain_ign2", 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    expect_out("drain_after", 0, 1, 0, 32'h0, 32'h508, 0, 32'h0, 0);
    @(negedge clk);
    expect_out("underflow_empty", 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
    @(negedge clk);
    ex_valid = 0;
    repeat (2) @(negedge clk);

    // Async reset mid-stream: clears pulse, underflow and queued records without an edge.
    push_rec(32'h900, 1, 0, 32'h0);
    push_rec(32'h904, 1, 0, 32'h0);
    drive_ex(1, 0, 32'h0);
    @(posedge clk);
    #1;
    check1("pre_reset_wrp", {31'd0, wrp}, 32'd1);
    ex_valid = 0;
    rst_n = 0;
    #1;
    check1("async_clear", {28'd0, wrt, wrp, redirect, underflow}, 32'd0);
    check1("async_f_ready", {31'd0, f_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    drive_ex(1, 1, 32'h950);
    expect_out("post_reset_empty", 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
    @(negedge clk);
    ex_valid = 0;
    repeat (2) @(negedge clk);

    check1("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Update-side counterpart of the 16-entry tagged 1-bit branch predictor table.
- Queues the lookup result (hit, prediction, cached target) for each fetched instruction in order.
- Compares each queued record against the actual outcome at execute and produces:
  - the table write bus (wrt/wrp/Pin/BdestIN/PC4d);
  - a fetch redirect and pipeline flush on misprediction.

Parameters:
- DEPTH, 8, number of in-flight fetch records in the FIFO (power of two, 2..32)
- DRAIN_CYCLES, 2, cycles after a redirect during which ex_valid is ignored, because wrong-path instructions are still in flight

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_valid  in  1  fetch pushes one record this cycle
- f_pc4  in  32  PC+4 of fetched instruction (table lookup index)
- f_hit  in  1  table H for f_pc4
- f_pred  in  1  table P for f_pc4
- f_bdest  in  32  table Bdest for f_pc4
- f_ready  out  1  FIFO can accept a push (not full, or a pop occurs this cycle)
- ex_valid  in  1  oldest instruction resolves this cycle
- ex_is_branch  in  1  resolved instruction is a conditional branch
- ex_taken  in  1  actual branch direction
- ex_target  in  32  actual branch target
- wrt  out  1  write tag+dest
- wrp  out  1  write prediction bit
- Pin  out  1  prediction bit to write
- BdestIN  out  32  destination to write
- PC4d  out  32  PC+4 of resolved instruction (table write index/tag)
- redirect  out  1  one-cycle flush/redirect pulse
- redirect_pc  out  32  correct next fetch address
- underflow  out  1  sticky: ex_valid seen with FIFO empty in ACTIVE state

Behaviour:
- Reset (async, rst_n=0):
  - outputs: wrt=wrp=Pin=redirect=underflow=0; BdestIN=PC4d=redirect_pc=0.
  - FIFO emptied; state=ACTIVE; drain counter=0.
  - f_ready is combinational and reads 1 while reset is held.
  - Reset asserted mid-operation discards all records and any pending pulse.
- Record: {pc4, hit, pred, bdest}.
  - Push when f_valid & f_ready.
  - Pop head when ex_valid is accepted.
  - Simultaneous push+pop when full is legal; count is unchanged.
  - A push when not ready is dropped silently.
- predicted_taken = hit & pred.
- Resolution of head at cycle T. All outputs below are registered and valid at T+1 for exactly one cycle:
  - Branch, taken:
    - wrt=1, wrp=1, Pin=1, BdestIN=ex_target.
    - mispredict if !predicted_taken or bdest != ex_target.
  - Branch, not taken:
    - if hit: wrp=1, Pin=0, wrt=0.
    - if !hit: no write.
    - mispredict if predicted_taken.
  - Non-branch with predicted_taken (alias):
    - wrp=1, Pin=0.
    - mispredict; correct path is pc4.
  - Non-branch with !predicted_taken: no write, no redirect.
  - PC4d = head pc4 whenever wrt or wrp is set.
- Mispredict handling:
  - redirect=1 at T+1.
  - redirect_pc = ex_target if actually taken, else head pc4.
  - FIFO cleared at the T edge; a push presented in cycle T is dropped as wrong path.
  - State -> RECOVER with counter=DRAIN_CYCLES.
- FSM:
  - ACTIVE: normal operation.
  - RECOVER:
    - ex_valid ignored, no pop, no writes, underflow not set.
    - pushes are accepted (correct path).
    - counter decrements each cycle; returns to ACTIVE the cycle after the counter reaches 1.
    - With DRAIN_CYCLES=0, RECOVER is skipped.
- ex_valid with FIFO empty in ACTIVE: no write, no redirect, underflow set until reset.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- When defined, adds two outputs:
  - stat_branches (32): count of resolved conditional branches.
  - stat_mispred (32): count of redirects.
  - Both reset to 0, wrap modulo 2^32, and increment in the same cycle redirect/update outputs assert.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then push {pc4=0x104, hit=0, pred=0}; resolve branch taken, target 0x200 -> next cycle wrt=1, wrp=1, Pin=1, BdestIN=0x200, PC4d=0x104, redirect=1, redirect_pc=0x200.
- Push {0x108, hit=1, pred=1, bdest=0x300}; resolve taken, target 0x300 -> wrt=wrp=Pin=1, redirect=0.
- Push {0x10C, hit=1, pred=1, bdest=0x300}; resolve not taken -> wrp=1, Pin=0, wrt=0, redirect=1, redirect_pc=0x10C.
- Push DEPTH=8 records without pops -> f_ready=0; the 9th push is dropped. A push+pop in the same cycle is accepted; count stays 8.
- Mispredict at T with a push at T and ex_valid at T+1, T+2 -> the T push is dropped, ex_valid ignored, underflow stays 0; a push at T+1 is resolved normally at T+3.
- ex_valid with empty FIFO -> underflow=1 and no write. Asserting rst_n=0 mid-stream clears underflow and FIFO immediately, without a clock edge.
